sp_ram_gen: RTL and testbench

Parametrised single-port synchronous RAM, the generalised successor to the fixed 8-bit × 2K single-port block RAM instances used in the AES datapath (S-box/key/state buffers). Adds configurable width/depth, per-byte write enables, three selectable write-read collision modes, a post-reset memory-clear sequencer with `busy` indication, and a read-valid strobe. Inferred RAM (no vendor primitive), so it maps to BSRAM on GW2A or to registers in simulation.

---
 rtl/sp_ram_gen_pkg.sv | 14 +
 rtl/sp_ram_gen_if.sv | 22 ++
 rtl/sp_ram_gen_clear_ctrl.sv | 37 +++
 rtl/sp_ram_gen.sv | 115 +++++++++++
 tb/tb_sp_ram_gen.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/sp_ram_gen_pkg.sv
// rtl/sp_ram_gen_pkg.sv - write-mode constants and clear-FSM state encoding (package sp_ram_pkg)
package sp_ram_pkg;

  // Collision behaviour of dout when the access is a write
  localparam int WM_NORMAL            = 0;
  localparam int WM_WRITE_THROUGH     = 1;
  localparam int WM_READ_BEFORE_WRITE = 2;

  // Clear sequencer state
  typedef logic [0:0] clr_state_t;
  localparam clr_state_t CLEAR = 1'b0;
  localparam clr_state_t READY = 1'b1;

endpackage

// File: rtl/sp_ram_gen_if.sv
// rtl/sp_ram_gen_if.sv - access bus of the single-port RAM
interface sp_ram_gen_if #(
  parameter int DATA_W = 8,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 11
);
  localparam int NBYTES = DATA_W / BYTE_W;

  logic              ce;
  logic              oce;
  logic              wre;
  logic [NBYTES-1:0] be;
  logic [ADDR_W-1:0] ad;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rvalid;
  logic              busy;

  modport master (output ce, oce, wre, be, ad, din, input dout, rvalid, busy);
  modport slave  (input ce, oce, wre, be, ad, din, output dout, rvalid, busy);

endinterface

// File: rtl/sp_ram_gen_clear_ctrl.sv
// rtl/sp_ram_gen_clear_ctrl.sv - post-reset memory clear sequencer (module sp_ram_clear_ctrl)
module sp_ram_clear_ctrl
  import sp_ram_pkg::*;
#(
  parameter int ADDR_W         = 11,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_clr_we
);

  localparam clr_state_t START_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  clr_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;

  // Walk the address space once, zeroing one word per cycle, then hand over to the user port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= START_STATE;
      r_addr  <= '0;
    end else if (r_state == CLEAR) begin
      r_addr <= r_addr + 1'b1;
      if (r_addr == {ADDR_W{1'b1}}) begin
        r_state <= READY;
      end
    end
  end

  assign o_busy     = (r_state == CLEAR);
  assign o_clr_we   = (r_state == CLEAR);
  assign o_clr_addr = r_addr;

endmodule

// File: rtl/sp_ram_gen.sv
// rtl/sp_ram_gen.sv - parametrised single-port RAM; SP_RAM_OREG_EN adds an oce-gated output register
module sp_ram_gen
  import sp_ram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int BYTE_W         = 8,
  parameter int ADDR_W         = 11,
  parameter int WRITE_MODE     = WM_NORMAL,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  sp_ram_gen_if.slave bus
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int DEPTH  = 1 << ADDR_W;

  if (DATA_W % BYTE_W != 0) begin : g_bad_width
    $error("sp_ram_gen: DATA_W must be a multiple of BYTE_W");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_s1;
  logic              r_s1_v;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_acc;
  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] w_merged;

  sp_ram_clear_ctrl #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .clk        (clk),
    .reset      (reset),
    .o_busy     (w_busy),
    .o_clr_addr (w_clr_addr),
    .o_clr_we   (w_clr_we)
  );

  assign w_acc = bus.ce & ~w_busy;
  assign w_rd  = r_mem[bus.ad];

  // Old word with the enabled bytes replaced by din
  always_comb begin
    w_merged = w_rd;
    for (int i = 0; i < NBYTES; i++) begin
      if (bus.be[i]) begin
        w_merged[i*BYTE_W +: BYTE_W] = bus.din[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Array write port: clear sequencer owns it while busy, user port otherwise
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_acc && bus.wre) begin
      r_mem[bus.ad] <= w_merged;
    end
  end

  // Stage-1 read register; on writes its content depends on the collision mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1   <= '0;
      r_s1_v <= 1'b0;
    end else begin
      r_s1_v <= 1'b0;
      if (w_acc) begin
        if (!bus.wre) begin
          r_s1   <= w_rd;
          r_s1_v <= 1'b1;
        end else if (WRITE_MODE == WM_WRITE_THROUGH) begin
          r_s1   <= w_merged;
          r_s1_v <= 1'b1;
        end else if (WRITE_MODE == WM_READ_BEFORE_WRITE) begin
          r_s1   <= w_rd;
          r_s1_v <= 1'b1;
        end
      end
    end
  end

`ifdef SP_RAM_OREG_EN
  logic [DATA_W-1:0] r_s2;
  logic              r_s2_v;

  // Stage-2 output register; a result arriving while oce is low is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2   <= '0;
      r_s2_v <= 1'b0;
    end else begin
      r_s2_v <= r_s1_v & bus.oce;
      if (bus.oce) begin
        r_s2 <= r_s1;
      end
    end
  end

  assign bus.dout   = r_s2;
  assign bus.rvalid = r_s2_v;
`else
  assign bus.dout   = r_s1;
  assign bus.rvalid = r_s1_v;
`endif

  assign bus.busy = w_busy;

endmodule

// File: tb/tb_sp_ram_gen.sv
// tb/tb_sp_ram_gen.sv - directed bench: three write modes side by side, 32-bit x 16 words
module tb_sp_ram_gen;
  import sp_ram_pkg::*;

  localparam int DW = 32;
  localparam int BW = 8;
  localparam int AW = 4;
  localparam int NB = DW / BW;
`ifdef SP_RAM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          ce    = 1'b0;
  logic          oce   = 1'b1;
  logic          wre   = 1'b0;
  logic [NB-1:0] be    = '0;
  logic [AW-1:0] ad    = '0;
  logic [DW-1:0] din   = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc;
  logic rv_seen;

  always #5 clk = ~clk;

  sp_ram_gen_if #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW)) if_nm ();
  sp_ram_gen_if #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW)) if_wt ();
  sp_ram_gen_if #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW)) if_rb ();

  assign if_nm.ce = ce;  assign if_nm.oce = oce; assign if_nm.wre = wre;
  assign if_nm.be = be;  assign if_nm.ad  = ad;  assign if_nm.din = din;
  assign if_wt.ce = ce;  assign if_wt.oce = oce; assign if_wt.wre = wre;
  assign if_wt.be = be;  assign if_wt.ad  = ad;  assign if_wt.din = din;
  assign if_rb.ce = ce;  assign if_rb.oce = oce; assign if_rb.wre = wre;
  assign if_rb.be = be;  assign if_rb.ad  = ad;  assign if_rb.din = din;

  sp_ram_gen #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW), .WRITE_MODE(WM_NORMAL), .CLEAR_ON_RESET(1))
    u_nm (.clk(clk), .reset(reset), .bus(if_nm));
  sp_ram_gen #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW), .WRITE_MODE(WM_WRITE_THROUGH), .CLEAR_ON_RESET(1))
    u_wt (.clk(clk), .reset(reset), .bus(if_wt));
  sp_ram_gen #(.DATA_W(DW), .BYTE_W(BW), .ADDR_W(AW), .WRITE_MODE(WM_READ_BEFORE_WRITE), .CLEAR_ON_RESET(1))
    u_rb (.clk(clk), .reset(reset), .bus(if_rb));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] b);
    ce = 1'b1; wre = 1'b1; ad = a; din = d; be = b;
    tick();
    ce = 1'b0; wre = 1'b0;
    repeat (LAT-1) tick();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    ce = 1'b1; wre = 1'b0; ad = a;
    tick();
    ce = 1'b0;
    repeat (LAT-1) tick();
  endtask

  // Counts busy cycles while hammering the port with writes that must be ignored
  task automatic wait_clear(output int n, output logic rv);
    n  = 0;
    rv = 1'b0;
    while (if_rb.busy && n < 100) begin
      ce = 1'b1; wre = 1'b1; be = '1; din = '1; ad = AW'(n);
      tick();
      rv = rv | if_rb.rvalid | if_wt.rvalid;
      n++;
    end
    ce = 1'b0; wre = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_dout",   if_rb.dout,   32'h0);
    check("rst_rvalid", 32'(if_rb.rvalid), 32'h0);
    check("rst_busy",   32'(if_rb.busy),   32'h1);
    reset = 1'b0;

    wait_clear(n_cyc, rv_seen);
    check("clr_cycles", 32'(n_cyc), 32'd16);
    check("clr_no_rvalid", 32'(rv_seen), 32'h0);
    check("clr_busy_low", 32'(if_rb.busy), 32'h0);

    for (int a = 0; a < 16; a++) begin
      rd(AW'(a));
      check($sformatf("clr_rd%0d", a), if_rb.dout, 32'h0);
    end
    check("rd_rvalid", 32'(if_rb.rvalid), 32'h1);

    wr(4'd5, 32'hAABBCCDD, 4'hF);
    wr(4'd5, 32'h00001100, 4'b0010);
    rd(4'd5);
    check("be_merge", if_rb.dout, 32'hAABB11DD);
    wr(4'd5, 32'hFFFFFFFF, 4'h0);
    rd(4'd5);
    check("be_zero", if_rb.dout, 32'hAABB11DD);

    wr(4'd3, 32'h00000012, 4'hF);
    rd(4'd3);
    check("m_pre_nm", if_nm.dout, 32'h12);
    wr(4'd3, 32'h00000034, 4'hF);
    check("m0_dout",   if_nm.dout, 32'h12);
    check("m0_rvalid", 32'(if_nm.rvalid), 32'h0);
    check("m1_dout",   if_wt.dout, 32'h34);
    check("m1_rvalid", 32'(if_wt.rvalid), 32'h1);
    check("m2_dout",   if_rb.dout, 32'h12);
    check("m2_rvalid", 32'(if_rb.rvalid), 32'h1);
    rd(4'd3);
    check("m_post", if_rb.dout, 32'h34);

    ce = 1'b1; wre = 1'b1; ad = 4'd9; din = 32'hDEADBEEF; be = 4'hF;
    tick();
    wre = 1'b0;
    tick();
    ce = 1'b0;
    repeat (LAT-1) tick();
    check("wr_rd_b2b", if_rb.dout, 32'hDEADBEEF);
    check("wr_rd_b2b_v", 32'(if_rb.rvalid), 32'h1);

    wr(4'd15, 32'h0F0F0F0F, 4'hF);
    wr(4'd0,  32'h11111111, 4'hF);
    rd(4'd15);
    check("top_addr", if_rb.dout, 32'h0F0F0F0F);
    rd(4'd0);
    check("addr0", if_rb.dout, 32'h11111111);

`ifdef SP_RAM_OREG_EN
    wr(4'd0, 32'h000000A0, 4'hF);
    wr(4'd1, 32'h000000A1, 4'hF);
    wr(4'd2, 32'h000000A2, 4'hF);
    ce = 1'b1; wre = 1'b0; ad = 4'd0;
    tick();
    ad = 4'd1;
    tick();
    check("oreg_r0", if_rb.dout, 32'hA0);
    check("oreg_r0_v", 32'(if_rb.rvalid), 32'h1);
    ad = 4'd2; oce = 1'b0;
    tick();
    check("oreg_drop", if_rb.dout, 32'hA0);
    check("oreg_drop_v", 32'(if_rb.rvalid), 32'h0);
    ce = 1'b0; oce = 1'b1;
    tick();
    check("oreg_r2", if_rb.dout, 32'hA2);
    check("oreg_r2_v", 32'(if_rb.rvalid), 32'h1);
`endif

    rd(4'd15);
    reset = 1'b1;
    #1;
    check("arst_dout",   if_rb.dout, 32'h0);
    check("arst_rvalid", 32'(if_rb.rvalid), 32'h0);
    check("arst_busy",   32'(if_rb.busy), 32'h1);
    reset = 1'b0;
    repeat (7) tick();
    check("busy_mid", 32'(if_rb.busy), 32'h1);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    wait_clear(n_cyc, rv_seen);
    check("reclr_cycles", 32'(n_cyc), 32'd16);
    rd(4'd15);
    check("reclr_rd15", if_rb.dout, 32'h0);
    rd(4'd0);
    check("reclr_rd0", if_rb.dout, 32'h0);
    rd(4'd9);
    check("reclr_rd9", if_rb.dout, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
